// File: rtl/mem_ext_pkg.sv
// Shared geometry and queued-request record for the external data-memory port.
package mem_ext_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 1024;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_w(DEPTH);

    // oor is resolved at enqueue so the head can be retired without re-decoding the address
    typedef struct packed {
        logic              we;
        logic              oor;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
    } ext_req_t;

endpackage

// File: rtl/dmem_ext_port_if.sv
// External debug/load port bundle: requester drives master, dmem_ext_port sits on slave.
interface dmem_ext_port_if;
    import mem_ext_pkg::*;

    logic [ADDR_W-1:0] addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [DATA_W-1:0] rdata_ext;
    logic              rvalid_ext;
    logic              full_ext;
    logic              err_ext;

    modport master (
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        input  rdata_ext, rvalid_ext, full_ext, err_ext
    );

    modport slave (
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        output rdata_ext, rvalid_ext, full_ext, err_ext
    );

endinterface

// File: rtl/ext_req_fifo.sv
// Synchronous in-order queue of external requests; FIFO_DEPTH must be a power of two.
module ext_req_fifo
    import mem_ext_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        push,
    input  logic                        pop,
    input  ext_req_t                    din,
    output ext_req_t                    dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ext_req_t         slots [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: payload slots carry no reset; occupancy lives only in the pointers and count.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= din;
    end

    assign dout  = slots[rd_ptr];
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_ext_port.sv
// Shares the single-port data memory between the CPU (priority) and a queued external port.
module dmem_ext_port
    import mem_ext_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    dmem_ext_port_if.slave    ext,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wen,
    input  logic              cpu_ren,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [IDX_W-1:0]  mem_idx,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-4:0] WORD_LIMIT = (ADDR_W-3)'(DEPTH);

    ext_req_t                      push_req;
    ext_req_t                      head;
    logic                          push_valid;
    logic                          push;
    logic                          pop;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          cpu_act;
    logic                          err_set;
    logic                          rd_v1;
    logic                          rd_oor1;
    logic                          rd_v2;
    logic [DATA_W-1:0]             rdata_q;
    logic                          err_q;
    logic                          unused_bits;

    assign push_valid = ext.wen_ext ^ ext.ren_ext;
    assign push_req   = '{we:    ext.wen_ext,
                          oor:   (ext.addr_ext[ADDR_W-1:3] >= WORD_LIMIT),
                          idx:   ext.addr_ext[3 +: IDX_W],
                          wdata: ext.wdata_ext};

    assign cpu_act = enable & (cpu_wen | cpu_ren);
    assign pop     = ~cpu_act & ~empty;
    // A full queue still takes a push when the head leaves in the same cycle
    assign push    = push_valid & (~full | pop);

    ext_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mem_idx   = head.idx;
        mem_wdata = head.wdata;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (arst) begin
            mem_wen = 1'b0;
            mem_ren = 1'b0;
        end else if (cpu_act) begin
            mem_idx   = cpu_addr[3 +: IDX_W];
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = cpu_ren;
        end else if (pop) begin
            mem_wen = head.we & ~head.oor;
            mem_ren = ~head.we & ~head.oor;
        end
    end

    assign err_set = (ext.wen_ext & ext.ren_ext)
                   | (push_valid & full & ~pop)
                   | (pop & head.oor);

    // Read return: grant -> memory access -> capture, so rvalid lands two cycles after grant
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_v1   <= 1'b0;
            rd_oor1 <= 1'b0;
            rd_v2   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rd_v1   <= pop & ~head.we;
            rd_oor1 <= head.oor;
            rd_v2   <= rd_v1;
            if (rd_v1) rdata_q <= rd_oor1 ? '0 : mem_rdata;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign ext.rdata_ext  = rdata_q;
    assign ext.rvalid_ext = rd_v2;
    assign ext.full_ext   = full;
    assign ext.err_ext    = err_q;
    assign cpu_rdata      = mem_rdata;

    assign unused_bits = ^{cpu_addr[ADDR_W-1:IDX_W+3], cpu_addr[2:0],
                           ext.addr_ext[2:0], fifo_count};

endmodule

// File: tb/tb_dmem_ext_port.sv
// Randomised and directed bench for dmem_ext_port against a queue-level model of the port.
module tb_dmem_ext_port;
    import mem_ext_pkg::*;

    localparam int QD = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic              enable;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wen;
    logic              cpu_ren;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic [IDX_W-1:0]  mem_idx;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dmem_ext_port_if ext_if ();

    dmem_ext_port #(.FIFO_DEPTH(QD)) dut (
        .clk       (clk),
        .arst      (arst),
        .enable    (enable),
        .ext       (ext_if),
        .cpu_addr  (cpu_addr),
        .cpu_wen   (cpu_wen),
        .cpu_ren   (cpu_ren),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_idx   (mem_idx),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical single-port memory the DUT drives
    logic [DATA_W-1:0] phys [DEPTH];
    always @(posedge clk) begin
        if (mem_wen) phys[mem_idx] <= mem_wdata;
        if (mem_ren) mem_rdata <= phys[mem_idx];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          we;
        bit          oor;
        int unsigned idx;
        logic [63:0] wdata;
    } m_req_t;

    typedef struct {
        longint      due;
        logic [63:0] data;
    } m_rsp_t;

    m_req_t      mq[$];
    m_rsp_t      mr[$];
    logic [63:0] ref_mem [DEPTH];
    bit          m_err;
    longint      cyc = 0;

    always @(negedge clk) begin : model
        bit          c_act, m_pop, full_before, e_wen, e_ren, e_rv;
        int unsigned e_idx;
        logic [63:0] e_wd, wi;
        m_req_t      h, r;
        m_rsp_t      s;
        if (arst) begin
            check("rst_mem_wen", mem_wen, 0);
            check("rst_mem_ren", mem_ren, 0);
            check("rst_rvalid", ext_if.rvalid_ext, 0);
            check("rst_full", ext_if.full_ext, 0);
            check("rst_err", ext_if.err_ext, 0);
            mq.delete();
            mr.delete();
            m_err = 0;
        end else begin
            c_act = enable && (cpu_wen || cpu_ren);
            m_pop = !c_act && (mq.size() > 0);
            e_wen = 0; e_ren = 0; e_idx = 0; e_wd = '0;
            if (c_act) begin
                e_wen = cpu_wen; e_ren = cpu_ren;
                e_idx = int'((cpu_addr >> 3) % DEPTH);
                e_wd  = cpu_wdata;
            end else if (m_pop) begin
                h = mq[0];
                e_wen = h.we && !h.oor;
                e_ren = !h.we && !h.oor;
                e_idx = h.idx;
                e_wd  = h.wdata;
            end
            check("mem_wen", mem_wen, e_wen);
            check("mem_ren", mem_ren, e_ren);
            if (e_wen || e_ren) check("mem_idx", mem_idx, e_idx);
            if (e_wen) check("mem_wdata", mem_wdata, e_wd);

            e_rv = (mr.size() > 0) && (mr[0].due == cyc);
            check("rvalid_ext", ext_if.rvalid_ext, e_rv);
            if (e_rv) begin
                s = mr.pop_front();
                check("rdata_ext", ext_if.rdata_ext, s.data);
            end
            check("full_ext", ext_if.full_ext, mq.size() == QD);
            check("err_ext", ext_if.err_ext, m_err);
            check("cpu_rdata", cpu_rdata, mem_rdata);

            // advance to the state after this posedge
            full_before = (mq.size() == QD);
            if (c_act && cpu_wen) ref_mem[int'((cpu_addr >> 3) % DEPTH)] = cpu_wdata;
            if (m_pop) begin
                h = mq.pop_front();
                if (h.oor) m_err = 1;
                if (!h.we) begin
                    s.due  = cyc + 2;
                    s.data = h.oor ? 64'h0 : ref_mem[h.idx];
                    mr.push_back(s);
                end else if (!h.oor) begin
                    ref_mem[h.idx] = h.wdata;
                end
            end
            if (ext_if.wen_ext && ext_if.ren_ext) begin
                m_err = 1;
            end else if (ext_if.wen_ext || ext_if.ren_ext) begin
                if (full_before && !m_pop) begin
                    m_err = 1;
                end else begin
                    wi      = ext_if.addr_ext >> 3;
                    r.we    = ext_if.wen_ext;
                    r.oor   = (wi >= DEPTH);
                    r.idx   = int'(wi % DEPTH);
                    r.wdata = ext_if.wdata_ext;
                    mq.push_back(r);
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_idle();
        ext_if.wen_ext = 1'b0;
        ext_if.ren_ext = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        arst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 arst = 1'b0;
    endtask

    // Enqueue a read, then wait for its strobe; lat counts cycles after the one following issue
    task automatic read_and_wait(input logic [63:0] addr, output logic [63:0] data,
                                 output int lat);
        bit seen;
        ext_if.addr_ext = addr;
        ext_if.ren_ext  = 1'b1;
        next_cycle();
        ext_idle();
        seen = 0;
        lat  = 0;
        data = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ext_if.rvalid_ext) begin
                seen = 1;
                data = ext_if.rdata_ext;
            end else begin
                lat++;
            end
        end
        if (!seen) check("rvalid_timeout", 0, 1);
        next_cycle();
    endtask

    function automatic logic [63:0] t2_data(input int i);
        return 64'h0A0A_0000_0000_0000 | 64'(i + 1);
    endfunction

    logic [63:0] rd;
    int          lat;
    int          seen_rv;
    int          seen_wr;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            phys[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_rdata        = '0;
        arst             = 1'b1;
        enable           = 1'b0;
        cpu_addr         = '0;
        cpu_wen          = 1'b0;
        cpu_ren          = 1'b0;
        cpu_wdata        = '0;
        ext_if.addr_ext  = '0;
        ext_if.wdata_ext = '0;
        ext_idle();
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        check("post_reset_err", ext_if.err_ext, 0);
        check("post_reset_full", ext_if.full_ext, 0);
        check("post_reset_rvalid", ext_if.rvalid_ext, 0);
        next_cycle();

        // 1: basic write then read with the CPU stopped
        ext_if.addr_ext  = 64'h10;
        ext_if.wdata_ext = 64'h123456789a;
        ext_if.wen_ext   = 1'b1;
        next_cycle();
        ext_idle();
        read_and_wait(64'h10, rd, lat);
        check("t1_rdata", rd, 64'h123456789a);
        check("t1_latency", lat, 2);

        // 2: CPU load holds the port for 8 cycles while 5 ext writes arrive
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_addr         = 64'h40;
            cpu_ren          = 1'b1;
            ext_if.wen_ext   = (i < 5);
            ext_if.addr_ext  = 64'h100 + 64'(8 * i);
            ext_if.wdata_ext = t2_data(i);
            @(negedge clk);
            if (i == 3) check("t2_not_full", ext_if.full_ext, 0);
            if (i == 3) check("t2_err_clear", ext_if.err_ext, 0);
            if (i == 4) check("t2_full", ext_if.full_ext, 1);
            if (i == 5) check("t2_err_drop", ext_if.err_ext, 1);
            next_cycle();
        end
        cpu_ren = 1'b0;
        ext_idle();
        repeat (6) next_cycle();
        for (int i = 0; i < 5; i++) begin
            read_and_wait(64'h100 + 64'(8 * i), rd, lat);
            check("t2_readback", rd, (i < 4) ? t2_data(i) : 64'h0);
        end

        // 3: read-after-write to the same word on consecutive cycles
        pulse_reset(2);
        ext_if.addr_ext  = 64'h118;
        ext_if.wdata_ext = 64'hBE;
        ext_if.wen_ext   = 1'b1;
        next_cycle();
        ext_idle();
        read_and_wait(64'h118, rd, lat);
        check("t3_raw", rd, 64'hBE);

        // 4: out-of-range read completes with zero data and flags an error
        pulse_reset(2);
        check("t4_err_before", ext_if.err_ext, 0);
        read_and_wait(64'h2000, rd, lat);
        check("t4_rdata", rd, 64'h0);
        check("t4_latency", lat, 2);
        check("t4_err", ext_if.err_ext, 1);

        // 5: simultaneous read and write is rejected
        pulse_reset(2);
        ext_if.addr_ext  = 64'h0;
        ext_if.wdata_ext = 64'hDEAD;
        ext_if.wen_ext   = 1'b1;
        ext_if.ren_ext   = 1'b1;
        next_cycle();
        ext_idle();
        @(negedge clk);
        check("t5_err", ext_if.err_ext, 1);
        check("t5_empty", ext_if.full_ext, 0);
        next_cycle();
        read_and_wait(64'h0, rd, lat);
        check("t5_mem_unchanged", rd, 64'h0);

        // 6: reset with three queued writes and one read in flight
        for (int i = 0; i < 4; i++) begin
            cpu_ren          = 1'b1;
            ext_if.ren_ext   = (i == 0);
            ext_if.wen_ext   = (i != 0);
            ext_if.addr_ext  = 64'h180 + 64'(8 * i);
            ext_if.wdata_ext = 64'h6600 + 64'(i);
            next_cycle();
        end
        cpu_ren = 1'b0;
        ext_idle();
        @(negedge clk);
        check("t6_full_before", ext_if.full_ext, 1);
        next_cycle();
        arst = 1'b1;
        @(negedge clk);
        check("t6_full_in_reset", ext_if.full_ext, 0);
        check("t6_err_in_reset", ext_if.err_ext, 0);
        next_cycle();
        arst = 1'b0;
        seen_rv = 0;
        seen_wr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_rv += int'(ext_if.rvalid_ext);
            seen_wr += int'(mem_wen);
        end
        check("t6_no_late_rvalid", seen_rv, 0);
        check("t6_queue_empty", seen_wr, 0);
        check("t6_err_after", ext_if.err_ext, 0);
        next_cycle();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            arst      = (!arst && ($urandom_range(0, 399) == 0));
            enable    = ($urandom_range(0, 3) != 0);
            r         = $urandom_range(0, 7);
            cpu_wen   = (r == 0);
            cpu_ren   = (r == 1 || r == 2);
            cpu_addr  = 64'h100 + 64'(8 * $urandom_range(0, 15));
            cpu_wdata = {$urandom, $urandom};
            r         = $urandom_range(0, 15);
            ext_if.wen_ext = (r <= 4) || (r == 10);
            ext_if.ren_ext = (r >= 5 && r <= 10);
            r = $urandom_range(0, 15);
            if (r <= 11)      ext_if.addr_ext = 64'h100 + 64'(8 * $urandom_range(0, 15));
            else if (r <= 13) ext_if.addr_ext = 64'(8 * $urandom_range(1020, 1023));
            else if (r == 14) ext_if.addr_ext = 64'(8 * $urandom_range(1024, 1030));
            else              ext_if.addr_ext = 64'hFFFF_0000_0000_0000;
            ext_if.addr_ext[2:0] = 3'($urandom_range(0, 7));
            ext_if.wdata_ext     = {$urandom, $urandom};
            next_cycle();
        end
        arst    = 1'b0;
        cpu_wen = 1'b0;
        cpu_ren = 1'b0;
        ext_idle();
        repeat (10) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
